// File: rtl/vn_packer.sv
// vn_packer
// Collects raw ring-oscillator samples, optionally removes bias with von
// Neumann pairing, and packs the surviving bits into a 32-bit data word
// plus an 8-bit key byte. A repetition-count health test watches the raw
// stream and, once tripped, latches an alarm and blocks every later word
// until reset.
//
// Parameters
//   VN_EN      1 = von Neumann debiasing, 0 = raw bits pass straight through
//   RCT_LIMIT  run length of identical raw bits that trips the alarm (2..255)
//
// Ports
//   CLK        system clock, rising edge
//   RST        asynchronous, active-high reset
//   BIT_IN     raw sample
//   BIT_VLD    BIT_IN is sampled on this edge
//   D_OUT      packed data word (first emitted bit in D_OUT[31])
//   K_OUT      packed key byte  (33rd emitted bit in K_OUT[7])
//   WORD_VLD   one-cycle pulse marking new D_OUT/K_OUT contents
//   FAIL       sticky repetition-count alarm
//   DBG_STATE  debias FSM state (0 = WAIT_FIRST, 1 = WAIT_SECOND)
//
// Handshake: BIT_VLD is a plain valid with no ready; every BIT_VLD high
// cycle consumes BIT_IN. WORD_VLD is a plain valid pulse with no ready;
// the consumer must take the word in the cycle it is presented.
module vn_packer #(
    parameter int VN_EN     = 1,
    parameter int RCT_LIMIT = 32
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        BIT_IN,
    input  logic        BIT_VLD,
    output logic [31:0] D_OUT,
    output logic [7:0]  K_OUT,
    output logic        WORD_VLD,
    output logic        FAIL,
    output logic        DBG_STATE
);

    typedef enum logic {
        WAIT_FIRST  = 1'b0,
        WAIT_SECOND = 1'b1
    } state_t;

    localparam logic [7:0] LIMIT    = 8'(RCT_LIMIT);
    localparam logic [5:0] LAST_BIT = 6'd39;

    state_t      state_q, state_d;
    logic        b0_q, b0_d;
    logic [39:0] acc_q, acc_d;
    logic [5:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  run_q, run_d;
    logic        prev_q, prev_d;
    logic        fail_q, fail_d;
    logic [31:0] d_out_q, d_out_d;
    logic [7:0]  k_out_q, k_out_d;
    logic        word_vld_q, word_vld_d;

    logic        emit;
    logic        emit_bit;
    logic        word_done;

    always_comb begin
        state_d    = state_q;
        b0_d       = b0_q;
        acc_d      = acc_q;
        bit_cnt_d  = bit_cnt_q;
        run_d      = run_q;
        prev_d     = prev_q;
        d_out_d    = d_out_q;
        k_out_d    = k_out_q;
        emit       = 1'b0;
        emit_bit   = 1'b0;
        word_done  = 1'b0;

        if (BIT_VLD) begin
            // Debias stage: decide whether this sample yields an output bit.
            if (VN_EN != 0) begin
                if (state_q == WAIT_FIRST) begin
                    b0_d    = BIT_IN;
                    state_d = WAIT_SECOND;
                end else begin
                    state_d = WAIT_FIRST;
                    if (b0_q != BIT_IN) begin
                        emit     = 1'b1;
                        emit_bit = b0_q;
                    end
                end
            end else begin
                emit     = 1'b1;
                emit_bit = BIT_IN;
            end

            // Repetition count on the raw stream. run_q == 0 means no
            // previous valid bit has been seen since reset.
            if (run_q == 8'd0 || BIT_IN != prev_q) begin
                run_d = 8'd1;
            end else if (run_q < LIMIT) begin
                run_d = run_q + 8'd1;
            end
            prev_d = BIT_IN;
        end

        // Shift left so the first bit of a word ends up in acc[39].
        if (emit) begin
            acc_d = {acc_q[38:0], emit_bit};
            if (bit_cnt_q == LAST_BIT) begin
                word_done = 1'b1;
                bit_cnt_d = 6'd0;
            end else begin
                bit_cnt_d = bit_cnt_q + 6'd1;
            end
        end

        // The alarm is evaluated with this edge's run count so a word that
        // completes on the tripping edge is already suppressed.
        fail_d     = fail_q | (BIT_VLD && run_d == LIMIT);
        word_vld_d = word_done && !fail_d;
        if (word_vld_d) begin
            d_out_d = acc_d[39:8];
            k_out_d = acc_d[7:0];
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= WAIT_FIRST;
            b0_q       <= 1'b0;
            acc_q      <= 40'd0;
            bit_cnt_q  <= 6'd0;
            run_q      <= 8'd0;
            prev_q     <= 1'b0;
            fail_q     <= 1'b0;
            d_out_q    <= 32'd0;
            k_out_q    <= 8'd0;
            word_vld_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            b0_q       <= b0_d;
            acc_q      <= acc_d;
            bit_cnt_q  <= bit_cnt_d;
            run_q      <= run_d;
            prev_q     <= prev_d;
            fail_q     <= fail_d;
            d_out_q    <= d_out_d;
            k_out_q    <= k_out_d;
            word_vld_q <= word_vld_d;
        end
    end

    assign D_OUT     = d_out_q;
    assign K_OUT     = k_out_q;
    assign WORD_VLD  = word_vld_q;
    assign FAIL      = fail_q;
    assign DBG_STATE = state_q;

endmodule

// File: tb/tb_vn_packer.sv
// Bench for vn_packer: two instances share one stimulus stream, one with
// debiasing (VN_EN=1) and one raw (VN_EN=0). A queue-based model predicts
// every output each cycle; directed scenarios add literal expectations.
module tb_vn_packer;

    localparam int LIMIT = 32;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        BIT_IN = 1'b0;
    logic        BIT_VLD = 1'b0;

    logic [31:0] d_out [2];
    logic [7:0]  k_out [2];
    logic        wv    [2];
    logic        fl    [2];
    logic        st    [2];

    int n_vec  = 0;
    int n_miss = 0;

    // ---------------- clock / reset ----------------
    always #5 CLK = ~CLK;

    vn_packer #(.VN_EN(1), .RCT_LIMIT(LIMIT)) u_vn (
        .CLK(CLK), .RST(RST), .BIT_IN(BIT_IN), .BIT_VLD(BIT_VLD),
        .D_OUT(d_out[0]), .K_OUT(k_out[0]), .WORD_VLD(wv[0]),
        .FAIL(fl[0]), .DBG_STATE(st[0])
    );

    vn_packer #(.VN_EN(0), .RCT_LIMIT(LIMIT)) u_raw (
        .CLK(CLK), .RST(RST), .BIT_IN(BIT_IN), .BIT_VLD(BIT_VLD),
        .D_OUT(d_out[1]), .K_OUT(k_out[1]), .WORD_VLD(wv[1]),
        .FAIL(fl[1]), .DBG_STATE(st[1])
    );

    // ---------------- behavioural model ----------------
    logic [0:0]  em_q0[$];     // emitted bits awaiting a full word, VN_EN=1
    logic [0:0]  em_q1[$];     // same for VN_EN=0
    logic        have_b0;
    logic        b0_val;
    int          run_len;
    logic        last_bit;
    logic        m_fail;
    logic [31:0] exp_d  [2];
    logic [7:0]  exp_k  [2];
    logic        exp_wv [2];

    task automatic model_reset();
        em_q0.delete();
        em_q1.delete();
        have_b0  = 1'b0;
        b0_val   = 1'b0;
        run_len  = 0;
        last_bit = 1'b0;
        m_fail   = 1'b0;
        for (int c = 0; c < 2; c++) begin
            exp_d[c]  = 32'd0;
            exp_k[c]  = 8'd0;
            exp_wv[c] = 1'b0;
        end
    endtask

    task automatic model_step(input logic v, input logic b);
        logic [39:0] w;
        exp_wv[0] = 1'b0;
        exp_wv[1] = 1'b0;
        if (v) begin
            if (run_len == 0 || b != last_bit) run_len = 1;
            else if (run_len < LIMIT) run_len++;
            last_bit = b;
            if (run_len == LIMIT) m_fail = 1'b1;

            if (have_b0) begin
                if (b0_val != b) em_q0.push_back(b0_val);
                have_b0 = 1'b0;
            end else begin
                b0_val  = b;
                have_b0 = 1'b1;
            end
            em_q1.push_back(b);

            if (em_q0.size() == 40) begin
                for (int i = 0; i < 40; i++) w[39-i] = em_q0[i];
                em_q0.delete();
                if (!m_fail) begin
                    exp_d[0]  = w[39:8];
                    exp_k[0]  = w[7:0];
                    exp_wv[0] = 1'b1;
                end
            end
            if (em_q1.size() == 40) begin
                for (int i = 0; i < 40; i++) w[39-i] = em_q1[i];
                em_q1.delete();
                if (!m_fail) begin
                    exp_d[1]  = w[39:8];
                    exp_k[1]  = w[7:0];
                    exp_wv[1] = 1'b1;
                end
            end
        end
    endtask

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
        end
    endtask

    int cyc = 0;
    int pcnt [2];
    int pulse_t[$];

    initial begin
        pcnt[0] = 0;
        pcnt[1] = 0;
    end

    // Compare process: outputs are stable at the falling edge.
    always @(negedge CLK) begin
        cyc++;
        for (int c = 0; c < 2; c++) begin
            check($sformatf("d_out[%0d]", c), 64'(d_out[c]), 64'(exp_d[c]));
            check($sformatf("k_out[%0d]", c), 64'(k_out[c]), 64'(exp_k[c]));
            check($sformatf("word_vld[%0d]", c), 64'(wv[c]), 64'(exp_wv[c]));
            check($sformatf("fail[%0d]", c), 64'(fl[c]), 64'(m_fail));
            if (wv[c] === 1'b1) pcnt[c]++;
        end
        check("state_vn", 64'(st[0]), 64'(have_b0));
        check("state_raw", 64'(st[1]), 64'd0);
        if (wv[0] === 1'b1) pulse_t.push_back(cyc);
    end

    // ---------------- driver tasks ----------------
    task automatic cycle(input logic v, input logic b);
        BIT_VLD = v;
        BIT_IN  = b;
        @(posedge CLK);
        if (!RST) model_step(v, b);
        #1;
    endtask

    task automatic pair(input logic a, input logic b);
        cycle(1'b1, a);
        cycle(1'b1, b);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0);
    endtask

    task automatic do_reset();
        BIT_VLD = 1'b0;
        RST = 1'b1;
        model_reset();
        @(posedge CLK);
        #1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
    endtask

    task automatic clear_counts();
        pcnt[0] = 0;
        pcnt[1] = 0;
        pulse_t.delete();
    endtask

    initial begin
        #20_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [39:0] word;
        int          bias;
        model_reset();
        #1;
        do_reset();
        check("rst_d_out", 64'(d_out[0]), 64'd0);
        check("rst_k_out", 64'(k_out[0]), 64'd0);
        check("rst_fail", 64'(fl[0]), 64'd0);

        // 40 pairs "1,0" -> one all-ones word; raw instance sees 1010...
        clear_counts();
        for (int i = 0; i < 40; i++) pair(1'b1, 1'b0);
        idle(3);
        check("ones_pulses", 64'(pcnt[0]), 64'd1);
        check("ones_d", 64'(d_out[0]), 64'hFFFFFFFF);
        check("ones_k", 64'(k_out[0]), 64'hFF);
        check("ones_fail", 64'(fl[0]), 64'd0);
        check("raw_alt_d", 64'(d_out[1]), 64'hAAAAAAAA);
        check("raw_alt_pulses", 64'(pcnt[1]), 64'd2);

        // Alternating pairs -> 0xAA pattern, then equal pairs emit nothing.
        do_reset();
        clear_counts();
        for (int i = 0; i < 40; i++) begin
            if (i % 2 == 0) pair(1'b1, 1'b0);
            else            pair(1'b0, 1'b1);
        end
        idle(3);
        check("alt_d", 64'(d_out[0]), 64'hAAAAAAAA);
        check("alt_k", 64'(k_out[0]), 64'hAA);
        check("alt_pulses", 64'(pcnt[0]), 64'd1);
        clear_counts();
        for (int i = 0; i < 100; i++) begin
            if (i % 2 == 0) pair(1'b0, 1'b0);
            else            pair(1'b1, 1'b1);
        end
        idle(3);
        check("eq_pulses", 64'(pcnt[0]), 64'd0);
        check("eq_hold_d", 64'(d_out[0]), 64'hAAAAAAAA);
        check("eq_hold_k", 64'(k_out[0]), 64'hAA);

        // Partial word discarded by reset.
        do_reset();
        for (int i = 0; i < 20; i++) pair(1'b1, 1'b0);
        cycle(1'b1, 1'b1);               // leave a latched b0 as well
        do_reset();
        clear_counts();
        for (int i = 0; i < 40; i++) pair(1'b0, 1'b1);
        idle(3);
        check("rstmid_pulses", 64'(pcnt[0]), 64'd1);
        check("rstmid_d", 64'(d_out[0]), 64'd0);
        check("rstmid_k", 64'(k_out[0]), 64'd0);

        // Raw pass-through with BIT_VLD every other cycle.
        do_reset();
        clear_counts();
        word = 40'h123456789A;
        for (int i = 39; i >= 0; i--) begin
            cycle(1'b1, word[i]);
            cycle(1'b0, 1'b0);
        end
        idle(3);
        check("raw_d", 64'(d_out[1]), 64'h12345678);
        check("raw_k", 64'(k_out[1]), 64'h9A);
        check("raw_pulses", 64'(pcnt[1]), 64'd1);

        // Back-to-back words 80 cycles apart.
        do_reset();
        clear_counts();
        for (int i = 0; i < 80; i++) pair(1'b1, 1'b0);
        idle(3);
        check("b2b_pulses", 64'(pulse_t.size()), 64'd2);
        if (pulse_t.size() == 2)
            check("b2b_gap", 64'(pulse_t[1] - pulse_t[0]), 64'd80);
        check("b2b_d", 64'(d_out[0]), 64'hFFFFFFFF);

        // Repetition-count alarm.
        do_reset();
        clear_counts();
        for (int i = 0; i < LIMIT - 1; i++) cycle(1'b1, 1'b1);
        check("rct_31_fail", 64'(fl[0]), 64'd0);
        cycle(1'b1, 1'b1);
        check("rct_32_fail", 64'(fl[0]), 64'd1);
        check("rct_32_fail_raw", 64'(fl[1]), 64'd1);
        for (int i = 0; i < 80; i++) pair(1'b1, 1'b0);
        idle(3);
        check("rct_no_pulse", 64'(pcnt[0]), 64'd0);
        check("rct_no_pulse_raw", 64'(pcnt[1]), 64'd0);
        check("rct_frozen_d", 64'(d_out[0]), 64'd0);
        check("rct_sticky", 64'(fl[0]), 64'd1);
        do_reset();
        check("rct_cleared", 64'(fl[0]), 64'd0);

        // Randomized segments with varying bias; biased runs trip the alarm.
        for (int seg = 0; seg < 8; seg++) begin
            do_reset();
            case (seg % 4)
                0: bias = 50;
                1: bias = 96;
                2: bias = 4;
                default: bias = 70;
            endcase
            for (int i = 0; i < 400; i++) begin
                if ($urandom_range(0, 399) == 0) do_reset();
                cycle($urandom_range(0, 3) != 0, $urandom_range(0, 99) < bias);
            end
        end
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
